// File: rtl/mc_ctrl_ws_if.sv
// rtl/mc_ctrl_ws_if.sv - instruction/memory/datapath control bundle for mc_ctrl_ws
//
// Signals:
//   opcode[2:0], op[1:0]  instruction fields from the instruction register
//   mem_ready             memory finished the current MREAD/MWRITE this cycle
//   loada..write          datapath register/mux/write-back controls
//   load_ir..load_addr    fetch and address controls
//   nsel[2:0]             register select, one-hot: 100 Rn, 010 Rd, 001 Rm
//   vsel[3:0]             write-back source, one-hot: 0001 C, 0100 imm, 1000 mdata
//   mem_cmd[1:0]          00 none, 01 read, 10 write
//   halted/mem_err/illegal terminal-state flags
// master: the controller; slave: the datapath/memory side.
interface mc_ctrl_ws_if;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       mem_ready;

    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       write;

    logic       load_ir;
    logic       load_pc;
    logic       reset_pc;
    logic       addr_sel;
    logic       load_addr;

    logic [2:0] nsel;
    logic [3:0] vsel;
    logic [1:0] mem_cmd;

    logic       halted;
    logic       mem_err;
    logic       illegal;

    modport master (
        input  opcode, op, mem_ready,
        output loada, loadb, loadc, loads, asel, bsel, write,
        output load_ir, load_pc, reset_pc, addr_sel, load_addr,
        output nsel, vsel, mem_cmd, halted, mem_err, illegal
    );

    modport slave (
        output opcode, op, mem_ready,
        input  loada, loadb, loadc, loads, asel, bsel, write,
        input  load_ir, load_pc, reset_pc, addr_sel, load_addr,
        input  nsel, vsel, mem_cmd, halted, mem_err, illegal
    );
endinterface

// File: rtl/mc_ctrl_ws.sv
// rtl/mc_ctrl_ws.sv - multicycle CPU controller with bounded memory wait states
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, forces RST
//   bus    mc_ctrl_ws_if.master: instruction fields and mem_ready in,
//          all datapath/fetch/memory controls and status flags out
// Parameters:
//   MAX_WAIT  memory wait cycles tolerated before FAULT (1..255)
//   CNT_W     wait-counter width, >= clog2(MAX_WAIT+1)
// All outputs are Moore: decoded from the state register, the wait counter
// and nothing else.
module mc_ctrl_ws #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    mc_ctrl_ws_if.master     bus
);

    typedef enum logic [4:0] {
        S_RST     = 5'd0,
        S_IF1     = 5'd1,
        S_IF2     = 5'd2,
        S_UPDPC   = 5'd3,
        S_DECODE  = 5'd4,
        S_GETA    = 5'd5,
        S_GETB    = 5'd6,
        S_ALU     = 5'd7,
        S_WREG    = 5'd8,
        S_MOVIMM  = 5'd9,
        S_MOV1    = 5'd10,
        S_MOV2    = 5'd11,
        S_MOV3    = 5'd12,
        S_LS_A    = 5'd13,
        S_LS_ADD  = 5'd14,
        S_LS_ADDR = 5'd15,
        S_LD_MEM  = 5'd16,
        S_LD_WB   = 5'd17,
        S_ST_B    = 5'd18,
        S_ST_MEM  = 5'd19,
        S_HALT    = 5'd20,
        S_FAULT   = 5'd21,
        S_ILL     = 5'd22
    } state_t;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [2:0] NSEL_RN = 3'b100;
    localparam logic [2:0] NSEL_RD = 3'b010;
    localparam logic [2:0] NSEL_RM = 3'b001;

    localparam logic [3:0] VSEL_C     = 4'b0001;
    localparam logic [3:0] VSEL_IMM   = 4'b0100;
    localparam logic [3:0] VSEL_MDATA = 4'b1000;

    // Counter value held during the MAX_WAIT-th cycle of a wait state; a
    // not-ready cycle at this value is the last one tolerated.
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_load_q, is_load_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_RST;
            cnt_q     <= '0;
            is_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_load_q <= is_load_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_load_d = is_load_q;

        case (state_q)
            S_RST:    state_d = S_IF1;
            S_IF1: begin
                if (bus.mem_ready)           state_d = S_IF2;
                else if (cnt_q == LAST_WAIT) state_d = S_FAULT;
                else                         cnt_d   = cnt_q + CNT_W'(1);
            end
            S_IF2:    state_d = S_UPDPC;
            S_UPDPC:  state_d = S_DECODE;
            S_DECODE: begin
                casez ({bus.opcode, bus.op})
                    5'b11010: state_d = S_MOVIMM;
                    5'b11000: state_d = S_MOV1;
                    5'b101??: state_d = S_GETA;
                    5'b01100: begin
                        state_d   = S_LS_A;
                        is_load_d = 1'b1;
                    end
                    5'b10000: begin
                        state_d   = S_LS_A;
                        is_load_d = 1'b0;
                    end
                    5'b111??: state_d = S_HALT;
                    default:  state_d = S_ILL;
                endcase
            end
            S_GETA:   state_d = S_GETB;
            S_GETB:   state_d = S_ALU;
            // CMP only updates status, so it never reaches write-back.
            S_ALU:    state_d = (bus.op == 2'b01) ? S_IF1 : S_WREG;
            S_WREG:   state_d = S_IF1;
            S_MOVIMM: state_d = S_IF1;
            S_MOV1:   state_d = S_MOV2;
            S_MOV2:   state_d = S_MOV3;
            S_MOV3:   state_d = S_IF1;
            S_LS_A:   state_d = S_LS_ADD;
            S_LS_ADD: state_d = S_LS_ADDR;
            S_LS_ADDR: state_d = is_load_q ? S_LD_MEM : S_ST_B;
            S_LD_MEM: begin
                if (bus.mem_ready)           state_d = S_LD_WB;
                else if (cnt_q == LAST_WAIT) state_d = S_FAULT;
                else                         cnt_d   = cnt_q + CNT_W'(1);
            end
            S_LD_WB:  state_d = S_IF1;
            S_ST_B:   state_d = S_ST_MEM;
            S_ST_MEM: begin
                if (bus.mem_ready)           state_d = S_IF1;
                else if (cnt_q == LAST_WAIT) state_d = S_FAULT;
                else                         cnt_d   = cnt_q + CNT_W'(1);
            end
            S_HALT:   state_d = S_HALT;
            S_FAULT:  state_d = S_FAULT;
            S_ILL:    state_d = S_ILL;
            default:  state_d = S_RST;
        endcase

        // Every fresh visit to a wait state starts with a zero count.
        if ((state_d != state_q) &&
            ((state_d == S_IF1) || (state_d == S_LD_MEM) || (state_d == S_ST_MEM))) begin
            cnt_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        bus.loada     = 1'b0;
        bus.loadb     = 1'b0;
        bus.loadc     = 1'b0;
        bus.loads     = 1'b0;
        bus.asel      = 1'b0;
        bus.bsel      = 1'b0;
        bus.write     = 1'b0;
        bus.load_ir   = 1'b0;
        bus.load_pc   = 1'b0;
        bus.reset_pc  = 1'b0;
        bus.addr_sel  = 1'b0;
        bus.load_addr = 1'b0;
        bus.nsel      = 3'b000;
        bus.vsel      = 4'b0000;
        bus.mem_cmd   = MEM_NONE;
        bus.halted    = 1'b0;
        bus.mem_err   = 1'b0;
        bus.illegal   = 1'b0;

        case (state_q)
            S_RST: begin
                bus.reset_pc = 1'b1;
                bus.load_pc  = 1'b1;
            end
            S_IF1: begin
                bus.addr_sel = 1'b1;
                bus.mem_cmd  = MEM_READ;
            end
            S_IF2: begin
                bus.addr_sel = 1'b1;
                bus.mem_cmd  = MEM_READ;
                bus.load_ir  = 1'b1;
            end
            S_UPDPC:  bus.load_pc = 1'b1;
            S_DECODE: ;
            S_GETA: begin
                bus.nsel  = NSEL_RN;
                bus.loada = 1'b1;
            end
            S_GETB: begin
                bus.nsel  = NSEL_RM;
                bus.loadb = 1'b1;
            end
            S_ALU: begin
                bus.loadc = 1'b1;
                bus.loads = 1'b1;
            end
            S_WREG: begin
                bus.nsel  = NSEL_RD;
                bus.vsel  = VSEL_C;
                bus.write = 1'b1;
            end
            S_MOVIMM: begin
                bus.nsel  = NSEL_RN;
                bus.vsel  = VSEL_IMM;
                bus.write = 1'b1;
            end
            S_MOV1: begin
                bus.nsel  = NSEL_RM;
                bus.loadb = 1'b1;
            end
            S_MOV2: begin
                bus.asel  = 1'b1;
                bus.loadc = 1'b1;
            end
            S_MOV3: begin
                bus.nsel  = NSEL_RD;
                bus.vsel  = VSEL_C;
                bus.write = 1'b1;
            end
            S_LS_A: begin
                bus.nsel  = NSEL_RN;
                bus.loada = 1'b1;
            end
            S_LS_ADD: begin
                bus.bsel  = 1'b1;
                bus.loadc = 1'b1;
            end
            S_LS_ADDR: bus.load_addr = 1'b1;
            S_LD_MEM: begin
                bus.mem_cmd = MEM_READ;
                bus.nsel    = NSEL_RD;
                bus.vsel    = VSEL_MDATA;
            end
            S_LD_WB: begin
                bus.nsel  = NSEL_RD;
                bus.vsel  = VSEL_MDATA;
                bus.write = 1'b1;
            end
            S_ST_B: begin
                bus.nsel  = NSEL_RD;
                bus.loadb = 1'b1;
            end
            S_ST_MEM: begin
                bus.asel    = 1'b1;
                bus.mem_cmd = MEM_WRITE;
                // C captures the store data only on the first cycle; the
                // counter is zero exactly then because entry clears it.
                bus.loadc   = (cnt_q == '0);
            end
            S_HALT:  bus.halted  = 1'b1;
            S_FAULT: bus.mem_err = 1'b1;
            S_ILL:   bus.illegal = 1'b1;
            default: ;
        endcase
    end

endmodule
